// File: rtl/sum_serializer.sv
// sum_serializer: turns a parallel WIDTH-bit sum word into an LSB-first stream
// of CHUNK-bit beats, with valid/ready handshakes on both sides. One word is in
// flight at a time, and the next word can load in the same cycle that the last
// beat of the current word leaves.
//
// Optional build macro: SUM_SERIALIZER_PARITY_EN
//   When this macro is defined, one extra beat follows the data beats. That beat
//   carries the even parity of the accepted word in bit 0, and OUT_last is high
//   only on that beat.
module sum_serializer #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             IN_clk,
  input  logic             IN_rst,
  input  logic             IN_valid,
  output logic             OUT_ready,
  input  logic [WIDTH-1:0] IN_data,
  output logic             OUT_valid,
  input  logic             IN_ready,
  output logic [CHUNK-1:0] OUT_data,
  output logic             OUT_last
);

  localparam int DBEATS = WIDTH / CHUNK;
`ifdef SUM_SERIALIZER_PARITY_EN
  localparam int BEATS = DBEATS + 1;
`else
  localparam int BEATS = DBEATS;
`endif
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("sum_serializer: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
  endgenerate

  logic [0:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shreg_r;
`ifdef SUM_SERIALIZER_PARITY_EN
  logic             par_r;
`endif

  logic             send_s;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic             beat_s;
  logic [CHUNK-1:0] data_s;

  // Handshake decode. Reset masks every output-facing strobe.
  always_comb begin
    send_s = 1'b0;
    if (state_r == SEND) begin
      send_s = 1'b1;
    end else begin
      send_s = 1'b0;
    end
    last_s   = send_s && (cnt_r == LAST_CNT);
    ready_s  = !IN_rst && ((state_r == IDLE) || (last_s && IN_ready));
    accept_s = IN_valid && ready_s;
    beat_s   = !IN_rst && send_s && IN_ready;
  end

  // Beat data: the low CHUNK bits of the shift register, or the parity beat.
  always_comb begin
    data_s = '0;
    if (send_s && !IN_rst) begin
      data_s = shreg_r[CHUNK-1:0];
`ifdef SUM_SERIALIZER_PARITY_EN
      if (cnt_r == LAST_CNT) begin
        data_s    = '0;
        data_s[0] = par_r;
      end else begin
        data_s = shreg_r[CHUNK-1:0];
      end
`endif
    end else begin
      data_s = '0;
    end
  end

  assign OUT_ready = ready_s;
  assign OUT_valid = send_s && !IN_rst;
  assign OUT_last  = last_s && !IN_rst;
  assign OUT_data  = data_s;

  // FSM, beat counter and shift register. A new word loads when accepted;
  // each non-final beat transfer shifts right by one chunk.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      shreg_r <= '0;
`ifdef SUM_SERIALIZER_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      state_r <= SEND;
      cnt_r   <= '0;
      shreg_r <= IN_data;
`ifdef SUM_SERIALIZER_PARITY_EN
      par_r   <= ^IN_data;
`endif
    end else if (beat_s) begin
      if (last_s) begin
        state_r <= IDLE;
      end else begin
        shreg_r <= shreg_r >> CHUNK;
        cnt_r   <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sum_serializer.sv
// Directed, table-driven bench for sum_serializer. Dut a uses WIDTH=8 and
// CHUNK=2. Dut b uses WIDTH=4 and CHUNK=4. Every table row gives the inputs for
// one cycle and the outputs expected in that same cycle. Outputs are sampled
// 1 ns after the inputs are driven on the falling edge.
module tb_sum_serializer;

`ifdef SUM_SERIALIZER_PARITY_EN
  localparam int BEATS_A = 5;
`else
  localparam int BEATS_A = 4;
`endif

  logic       clk;
  logic       a_rst, a_valid, a_ordy, a_rdy, a_oval, a_olast;
  logic [7:0] a_din;
  logic [1:0] a_odat;
  logic       b_rst, b_valid, b_ordy, b_rdy, b_oval, b_olast;
  logic [3:0] b_din;
  logic [3:0] b_odat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sel;
    logic       rst;
    logic       vin;
    logic [7:0] din;
    logic       rdy;
    logic       e_ordy;
    logic       e_oval;
    logic [7:0] e_dat;
    logic       e_last;
  } vec_t;

  vec_t vecs[$];

  sum_serializer #(.WIDTH(8), .CHUNK(2)) u_a (
    .IN_clk(clk), .IN_rst(a_rst), .IN_valid(a_valid), .OUT_ready(a_ordy),
    .IN_data(a_din), .OUT_valid(a_oval), .IN_ready(a_rdy),
    .OUT_data(a_odat), .OUT_last(a_olast)
  );

  sum_serializer #(.WIDTH(4), .CHUNK(4)) u_b (
    .IN_clk(clk), .IN_rst(b_rst), .IN_valid(b_valid), .OUT_ready(b_ordy),
    .IN_data(b_din), .OUT_valid(b_oval), .IN_ready(b_rdy),
    .OUT_data(b_odat), .OUT_last(b_olast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic sel, input logic rst, input logic vin, input logic [7:0] din,
                              input logic rdy, input logic e_ordy, input logic e_oval,
                              input logic [7:0] e_dat, input logic e_last);
    vec_t v;
    v.sel = sel; v.rst = rst; v.vin = vin; v.din = din; v.rdy = rdy;
    v.e_ordy = e_ordy; v.e_oval = e_oval; v.e_dat = e_dat; v.e_last = e_last;
    vecs.push_back(v);
  endfunction

  function automatic void fill();
    // dut a: reset rows
    add(0,1,0,8'h00,1, 0,0,8'd0,0);
    add(0,1,0,8'h00,1, 0,0,8'd0,0);
`ifdef SUM_SERIALIZER_PARITY_EN
    // B5 -> 1,1,3,2 then parity beat 1
    add(0,0,1,8'hB5,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd2,0);
    add(0,0,0,8'h00,1, 1,1,8'd1,1);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // B4 -> 0,1,3,2 then parity beat 0
    add(0,0,1,8'hB4,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd2,0);
    add(0,0,0,8'h00,1, 1,1,8'd0,1);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // dut b: BEATS=2 (data beat + parity beat)
    add(1,1,0,8'h00,1, 0,0,8'd0,0);
    add(1,0,1,8'h01,1, 1,0,8'd0,0);
    add(1,0,0,8'h00,1, 0,1,8'd1,0);
    add(1,0,0,8'h00,1, 1,1,8'd1,1);
    add(1,0,0,8'h00,1, 1,0,8'd0,0);
    add(1,0,1,8'h03,1, 1,0,8'd0,0);
    add(1,0,0,8'h00,1, 0,1,8'd3,0);
    add(1,0,0,8'h00,1, 1,1,8'd0,1);
    add(1,0,0,8'h00,1, 1,0,8'd0,0);
`else
    // single word B4 -> 0,1,3,2
    add(0,0,1,8'hB4,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 1,1,8'd2,1);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // stall three cycles on beat 2
    add(0,0,1,8'hB4,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd0,0);
    add(0,0,0,8'h00,0, 0,1,8'd1,0);
    add(0,0,0,8'h00,0, 0,1,8'd1,0);
    add(0,0,0,8'h00,0, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 1,1,8'd2,1);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // back-to-back B4 then 0F, zero bubble
    add(0,0,1,8'hB4,1, 1,0,8'd0,0);
    add(0,0,1,8'h0F,1, 0,1,8'd0,0);
    add(0,0,1,8'h0F,1, 0,1,8'd1,0);
    add(0,0,1,8'h0F,1, 0,1,8'd3,0);
    add(0,0,1,8'h0F,1, 1,1,8'd2,1);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd0,0);
    add(0,0,0,8'h00,1, 1,1,8'd0,1);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // stall on the last beat blocks the next word, then it loads
    add(0,0,1,8'h9C,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,1,8'h27,0, 0,1,8'd2,1);
    add(0,0,1,8'h27,1, 1,1,8'd2,1);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd1,0);
    add(0,0,0,8'h00,1, 0,1,8'd2,0);
    add(0,0,0,8'h00,1, 1,1,8'd0,1);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // reset after beat 2 of FF drops the word
    add(0,0,1,8'hFF,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,0,0,8'h00,1, 0,1,8'd3,0);
    add(0,1,0,8'h00,1, 0,0,8'd0,0);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    add(0,0,0,8'h00,1, 1,0,8'd0,0);
    // dut b: BEATS=1, one word per cycle
    add(1,1,0,8'h00,1, 0,0,8'd0,0);
    add(1,0,1,8'h01,1, 1,0,8'd0,0);
    add(1,0,1,8'h02,1, 1,1,8'd1,1);
    add(1,0,1,8'h03,1, 1,1,8'd2,1);
    add(1,0,0,8'h00,1, 1,1,8'd3,1);
    add(1,0,0,8'h00,1, 1,0,8'd0,0);
`endif
  endfunction

  initial begin
    int         nb;
    logic [7:0] w;
    logic [1:0] par_beat;
    bit         done;

    a_rst = 1'b1; a_valid = 1'b0; a_din = 8'h00; a_rdy = 1'b1;
    b_rst = 1'b1; b_valid = 1'b0; b_din = 4'h0; b_rdy = 1'b1;
    fill();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].sel == 1'b0) begin
        a_rst = vecs[i].rst; a_valid = vecs[i].vin; a_din = vecs[i].din; a_rdy = vecs[i].rdy;
        b_rst = 1'b1; b_valid = 1'b0;
      end else begin
        b_rst = vecs[i].rst; b_valid = vecs[i].vin; b_din = vecs[i].din[3:0]; b_rdy = vecs[i].rdy;
        a_rst = 1'b1; a_valid = 1'b0;
      end
      #1;
      if (vecs[i].sel == 1'b0) begin
        check("ready", i, {7'd0, a_ordy},  {7'd0, vecs[i].e_ordy});
        check("valid", i, {7'd0, a_oval},  {7'd0, vecs[i].e_oval});
        check("data",  i, {6'd0, a_odat},  vecs[i].e_dat);
        check("last",  i, {7'd0, a_olast}, {7'd0, vecs[i].e_last});
      end else begin
        check("ready", i, {7'd0, b_ordy},  {7'd0, vecs[i].e_ordy});
        check("valid", i, {7'd0, b_oval},  {7'd0, vecs[i].e_oval});
        check("data",  i, {4'd0, b_odat},  vecs[i].e_dat);
        check("last",  i, {7'd0, b_olast}, {7'd0, vecs[i].e_last});
      end
    end

    // Hand-written sequence: B4 with a ready pattern of 1,0,1,1,0,1...;
    // reassemble the word from the beats, bounded by a cycle budget.
    nb = 0; w = 8'h00; par_beat = 2'b11; done = 1'b0;
    @(negedge clk);
    b_rst = 1'b1; b_valid = 1'b0;
    a_rst = 1'b0; a_valid = 1'b1; a_din = 8'hB4; a_rdy = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      a_valid = 1'b0;
      a_rdy = ((c % 3) != 1);
      #1;
      if (a_oval && a_rdy) begin
        if (nb < 4) w[nb*2 +: 2] = a_odat;
        else par_beat = a_odat;
        nb++;
        if (a_olast) done = 1'b1;
      end
    end
    check("stall_done",  0, {7'd0, done}, 8'd1);
    check("stall_beats", 0, nb[7:0], BEATS_A[7:0]);
    check("stall_word",  0, w, 8'hB4);
`ifdef SUM_SERIALIZER_PARITY_EN
    check("stall_parity", 0, {6'd0, par_beat}, 8'd0);
`endif
    @(negedge clk);
    #1;
    check("stall_idle", 0, {7'd0, a_oval}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
